// File: rtl/bcd_scan_scheduler_pkg.sv
// bcd_scan_scheduler_pkg: shared FSM encoding, range limit and digit-pair helper
package bcd_scan_scheduler_pkg;
  typedef enum logic [1:0] {IDLE, CONV_HI, CONV_LO, COMMIT} state_t;
  localparam logic [5:0] MAX_BCD_VAL = 6'd59;
  localparam logic [3:0] BLANK_CODE_DEF = 4'hF;
  function automatic logic [7:0] pair_code(input logic [5:0] v, input logic [3:0] tens, input logic [3:0] units, input logic [3:0] blank);
    return (v > MAX_BCD_VAL) ? {blank, blank} : {tens, units};
  endfunction
endpackage

// File: rtl/bcd_scan_scheduler_scan_timer.sv
// bcd_scan_scheduler_scan_timer: digit-slot timebase and frame boundary generator
module bcd_scan_scheduler_scan_timer #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       reset,
  output logic [1:0] idx,
  output logic       slot_adv,
  output logic       frame_start
);
  localparam logic [19:0] LAST = 20'(SCAN_DIV - 1);
  logic [19:0] tick_cnt;
  // a slot ends on the last tick; a frame ends when the leftmost slot ends
  always_comb begin
    slot_adv = tick_cnt == LAST;
    frame_start = slot_adv && idx == 2'd3;
  end
  // tick counter wraps every slot, slot index wraps every frame
  always_ff @(posedge clk) begin
    tick_cnt <= (reset || slot_adv) ? '0 : tick_cnt + 20'd1;
    idx <= reset ? '0 : idx + {1'b0, slot_adv};
  end
endmodule

// File: rtl/bcd_scan_scheduler.sv
// bcd_scan_scheduler: two-pass BCD conversion per frame and 4-digit multiplexed scan
module bcd_scan_scheduler
  import bcd_scan_scheduler_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] hi_val,
  input  logic [5:0] lo_val,
  input  logic [1:0] blink_mask,
  input  logic       blink_tick,
  output logic [5:0] conv_bin,
  input  logic [3:0] conv_bcd1,
  input  logic [3:0] conv_bcd0,
  output logic [3:0] an,
  output logic [3:0] digit,
  output logic       frame_done
);
  state_t state, next_state;
  logic [1:0] idx;
  logic slot_adv, frame_start, pending, capture, blink_phase, blank;
  logic [5:0] snap_hi, snap_lo;
  logic [3:0][3:0] sh, d;
  bcd_scan_scheduler_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk(clk),
    .reset(reset),
    .idx(idx),
    .slot_adv(slot_adv),
    .frame_start(frame_start)
  );
  // state register
  always_ff @(posedge clk) begin
    state <= reset ? IDLE : next_state;
  end
  // a capture starts the fixed three-step pass sequence back to IDLE
  always_comb begin
    capture = state == IDLE && (frame_start || pending);
    next_state = (state == IDLE) ? (capture ? CONV_HI : IDLE) :
                 (state == CONV_HI) ? CONV_LO :
                 (state == CONV_LO) ? COMMIT : IDLE;
  end
  // converter operand comes from the snapshot matching the active pass
  always_comb begin
    conv_bin = (state == CONV_HI) ? snap_hi : (state == CONV_LO) ? snap_lo : '0;
  end
  // snapshot, shadow and committed digits; pending remembers a missed frame start
  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= 1'b1;
      snap_hi <= '0;
      snap_lo <= '0;
      sh <= '0;
      d <= '0;
      frame_done <= 1'b0;
    end else begin
      pending <= capture ? 1'b0 : (pending | frame_start);
      if (capture) begin
        snap_hi <= hi_val;
        snap_lo <= lo_val;
      end
      if (state == CONV_HI) sh[3:2] <= pair_code(snap_hi, conv_bcd1, conv_bcd0, BLANK_CODE);
      if (state == CONV_LO) sh[1:0] <= pair_code(snap_lo, conv_bcd1, conv_bcd0, BLANK_CODE);
      if (state == COMMIT) d <= sh;
      frame_done <= state == COMMIT;
    end
  end
  // blanking applies to the pair that owns the current slot during the dark blink phase
  always_comb begin
    blank = blink_phase && (idx[1] ? blink_mask[1] : blink_mask[0]);
  end
  // registered scan drive, one cycle behind the slot index
  always_ff @(posedge clk) begin
    blink_phase <= reset ? 1'b0 : blink_phase ^ blink_tick;
    an <= (reset || blank) ? 4'b1111 : ~(4'b0001 << idx);
    digit <= reset ? 4'd0 : blank ? BLANK_CODE : d[idx];
  end
endmodule

// File: tb/tb_bcd_scan_scheduler.sv
// tb_bcd_scan_scheduler: directed checks of conversion sequencing, scan, blink and reset
module tb_bcd_scan_scheduler;
  logic clk = 0;
  logic reset = 1;
  logic [5:0] hi_val = 0, lo_val = 0;
  logic [1:0] blink_mask = 0;
  logic blink_tick = 0;
  logic [5:0] conv_bin;
  logic [3:0] conv_bcd1, conv_bcd0, an, digit;
  logic frame_done;
  int checks = 0, failures = 0, cyc = 0, fd_cnt = 0, fd_base = 0;

  always #5 clk = ~clk;

  assign conv_bcd1 = 4'(conv_bin / 6'd10);
  assign conv_bcd0 = 4'(conv_bin % 6'd10);

  bcd_scan_scheduler #(.SCAN_DIV(4)) dut (
    .clk(clk), .reset(reset), .hi_val(hi_val), .lo_val(lo_val),
    .blink_mask(blink_mask), .blink_tick(blink_tick), .conv_bin(conv_bin),
    .conv_bcd1(conv_bcd1), .conv_bcd0(conv_bcd0), .an(an), .digit(digit),
    .frame_done(frame_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (frame_done === 1'b1) fd_cnt++;
    end
  endtask

  task automatic go(input int target);
    step(target - cyc);
  endtask

  task automatic scan(input string tag, input int at, input logic [3:0] ea, input logic [3:0] ed);
    go(at);
    chk({tag, "_an"}, 32'(an), 32'(ea));
    chk({tag, "_digit"}, 32'(digit), 32'(ed));
  endtask

  initial begin
    step(3);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_digit", 32'(digit), 0);
    chk("rst_conv_bin", 32'(conv_bin), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    hi_val = 12;
    lo_val = 34;
    reset = 0;
    cyc = 0;
    fd_cnt = 0;
    go(1);  chk("conv_hi", 32'(conv_bin), 12);
    go(2);  chk("conv_lo", 32'(conv_bin), 34);
    go(3);  chk("commit_fd_low", 32'(frame_done), 0);
            chk("commit_conv_bin", 32'(conv_bin), 0);
    go(4);  chk("first_fd", 32'(frame_done), 1);
    go(5);  chk("fd_one_cycle", 32'(frame_done), 0);
    scan("s1", 5, 4'b1101, 4'd3);
    scan("s2", 9, 4'b1011, 4'd2);
    scan("s3", 13, 4'b0111, 4'd1);
    lo_val = 35;
    scan("hold_old", 17, 4'b1110, 4'd4);
    go(19); chk("second_fd", 32'(frame_done), 1);
    scan("new_units", 20, 4'b1110, 4'd5);
    chk("fd_count_two_frames", 32'(fd_cnt), 2);
    scan("tens_after", 21, 4'b1101, 4'd3);
    hi_val = 62;
    scan("oor_s1", 37, 4'b1101, 4'd3);
    scan("oor_s2", 41, 4'b1011, 4'hF);
    scan("oor_s3", 45, 4'b0111, 4'hF);
    scan("oor_s0", 49, 4'b1110, 4'd5);
    hi_val = 12;
    blink_mask = 2'b10;
    blink_tick = 1;
    step(1);
    blink_tick = 0;
    scan("blk_s1", 53, 4'b1101, 4'd3);
    scan("blk_s2", 57, 4'b1111, 4'hF);
    scan("blk_s3", 61, 4'b1111, 4'hF);
    scan("blk_s0", 65, 4'b1110, 4'd5);
    blink_tick = 1;
    step(1);
    blink_tick = 0;
    scan("unblk_s2", 73, 4'b1011, 4'd2);
    scan("unblk_s3", 77, 4'b0111, 4'd1);
    go(81); chk("pre_rst_conv_lo", 32'(conv_bin), 35);
    reset = 1;
    step(1);
    chk("midrst_an", 32'(an), 32'hF);
    chk("midrst_digit", 32'(digit), 0);
    chk("midrst_fd", 32'(frame_done), 0);
    chk("midrst_conv_bin", 32'(conv_bin), 0);
    reset = 0;
    go(83); chk("restart_hi", 32'(conv_bin), 12);
    go(84); chk("restart_lo", 32'(conv_bin), 35);
    scan("cleared", 85, 4'b1110, 4'd0);
    go(86); chk("restart_fd", 32'(frame_done), 1);
    scan("restart_s1", 87, 4'b1101, 4'd3);
    fd_base = fd_cnt;
    go(151);
    chk("fd_per_frame", 32'(fd_cnt - fd_base), 4);
    scan("wrap_s2", 155, 4'b1011, 4'd2);
    scan("wrap_s3", 159, 4'b0111, 4'd1);
    scan("wrap_s0", 163, 4'b1110, 4'd5);
    scan("wrap_s1", 167, 4'b1101, 4'd3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
